// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM states and requester IDs.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_e;

    localparam logic REQ_IFETCH = 1'b0;
    localparam logic REQ_DCACHE = 1'b1;

    // Turn a requester ID into its one-hot strobe position.
    function automatic logic [1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant. On a tie, the requester that did not win last
// time is picked; last_grant starts at REQ_DCACHE so ifetch wins the first tie.
module rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic last_grant_reg;

    // Combinational pick among the current requests.
    always_comb begin
        gnt_valid = en && (req != 2'b00);
        gnt_id    = REQ_IFETCH;
        case (req)
            2'b01:   gnt_id = REQ_IFETCH;
            2'b10:   gnt_id = REQ_DCACHE;
            2'b11:   gnt_id = ~last_grant_reg;
            default: gnt_id = REQ_IFETCH;
        endcase
    end

    // Remember the winner of every taken grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= REQ_DCACHE;
        end else if (gnt_valid) begin
            last_grant_reg <= gnt_id;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the ifetch and dcache refill paths, one
// transaction at a time, with fetch-squash on flush and a sticky watchdog.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid_i,
    input  logic [1:0]          req_we_i,
    input  logic [2*ADDR_W-1:0] req_addr_i,
    input  logic [2*DATA_W-1:0] req_wdata_i,
    output logic [1:0]          req_ready_o,
    output logic [1:0]          resp_valid_o,
    output logic [DATA_W-1:0]   resp_data_o,
    input  logic                flush_i,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic                mem_req_we_o,
    output logic [ADDR_W-1:0]   mem_req_addr_o,
    output logic [DATA_W-1:0]   mem_req_wdata_o,
    input  logic                mem_resp_valid_i,
    input  logic [DATA_W-1:0]   mem_resp_data_i,
    output logic                busy_o,
    output logic                timeout_err_o
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WD_MAX  = '1;

    arb_state_e          state_reg, state_next;
    logic                owner_reg;
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic                squash_reg;
    logic [CNT_W-1:0]    wd_cnt_reg, wd_cnt_next;
    logic                timeout_err_reg;
    logic [1:0]          resp_valid_reg;
    logic [DATA_W-1:0]   resp_data_reg;

    logic                gnt_valid;
    logic                gnt_id;
    logic                resp_take;
    logic                flush_hit;
    logic                squash_now;

    rr_arbiter2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid_i),
        .en        (state_reg == IDLE),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // A flush only matters while an ifetch transaction is in flight; a flush
    // in the same cycle as the response already counts.
    assign flush_hit  = flush_i && (owner_reg == REQ_IFETCH) && (state_reg != IDLE);
    assign squash_now = squash_reg || flush_hit;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and the combinational handshake outputs.
    always_comb begin
        state_next      = state_reg;
        req_ready_o     = 2'b00;
        mem_req_valid_o = 1'b0;
        resp_take       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (gnt_valid) begin
                    req_ready_o = id_to_onehot(gnt_id);
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) begin
                    state_next = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (mem_resp_valid_i) begin
                    resp_take  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Watchdog counter: cleared on request acceptance, saturating while waiting.
    always_comb begin
        wd_cnt_next = wd_cnt_reg;
        if (state_reg == ISSUE && mem_req_ready_i) begin
            wd_cnt_next = '0;
        end else if (state_reg == WAIT_RESP && wd_cnt_reg != WD_MAX) begin
            wd_cnt_next = wd_cnt_reg + CNT_W'(1);
        end
    end

    // Request latch, squash tracking, watchdog and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_reg       <= REQ_IFETCH;
            we_reg          <= 1'b0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            squash_reg      <= 1'b0;
            wd_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
            resp_valid_reg  <= 2'b00;
            resp_data_reg   <= '0;
        end else begin
            if (state_reg == IDLE && gnt_valid) begin
                owner_reg <= gnt_id;
                we_reg    <= req_we_i[gnt_id];
                addr_reg  <= req_addr_i[gnt_id*ADDR_W +: ADDR_W];
                wdata_reg <= req_wdata_i[gnt_id*DATA_W +: DATA_W];
            end
            if (state_next == IDLE) begin
                squash_reg <= 1'b0;
            end else if (flush_hit) begin
                squash_reg <= 1'b1;
            end
            wd_cnt_reg <= wd_cnt_next;
            // Registered against the next cycle's counter so the flag is
            // visible in the same cycle the counter shows TIMEOUT-1.
            if (state_next == WAIT_RESP && wd_cnt_next == WD_LAST) begin
                timeout_err_reg <= 1'b1;
            end
            resp_valid_reg <= (resp_take && !squash_now) ? id_to_onehot(owner_reg) : 2'b00;
            if (resp_take) begin
                resp_data_reg <= mem_resp_data_i;
            end
        end
    end

    assign mem_req_we_o    = we_reg;
    assign mem_req_addr_o  = addr_reg;
    assign mem_req_wdata_o = wdata_reg;
    assign resp_valid_o    = resp_valid_reg;
    assign resp_data_o     = resp_data_reg;
    assign busy_o          = (state_reg != IDLE);
    assign timeout_err_o   = timeout_err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 16-cycle watchdog.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [1:0]          req_valid_i = '0;
    logic [1:0]          req_we_i = '0;
    logic [2*ADDR_W-1:0] req_addr_i = '0;
    logic [2*DATA_W-1:0] req_wdata_i = '0;
    logic [1:0]          req_ready_o;
    logic [1:0]          resp_valid_o;
    logic [DATA_W-1:0]   resp_data_o;
    logic                flush_i = 1'b0;
    logic                mem_req_valid_o;
    logic                mem_req_ready_i = 1'b0;
    logic                mem_req_we_o;
    logic [ADDR_W-1:0]   mem_req_addr_o;
    logic [DATA_W-1:0]   mem_req_wdata_o;
    logic                mem_resp_valid_i = 1'b0;
    logic [DATA_W-1:0]   mem_resp_data_i = '0;
    logic                busy_o;
    logic                timeout_err_o;

    int checks = 0;
    int failures = 0;
    int xfer_cnt = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid_i      (req_valid_i),
        .req_we_i         (req_we_i),
        .req_addr_i       (req_addr_i),
        .req_wdata_i      (req_wdata_i),
        .req_ready_o      (req_ready_o),
        .resp_valid_o     (resp_valid_o),
        .resp_data_o      (resp_data_o),
        .flush_i          (flush_i),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_we_o     (mem_req_we_o),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_wdata_o  (mem_req_wdata_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .busy_o           (busy_o),
        .timeout_err_o    (timeout_err_o)
    );

    always #5 clk = ~clk;

    // Count accepted memory requests mid-cycle.
    always @(negedge clk) begin
        if (mem_req_valid_o && mem_req_ready_i) xfer_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        settle();
        chk("rst_req_ready", 32'(req_ready_o), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid_o), 32'h0);
        chk("rst_resp_data", resp_data_o, 32'h0);
        chk("rst_mem_valid", 32'(mem_req_valid_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_err", 32'(timeout_err_o), 32'h0);

        // Single read by ifetch, response after 3 wait cycles
        req_valid_i = 2'b01;
        req_we_i = 2'b00;
        req_addr_i[31:0] = 32'h100;
        settle();
        chk("rd_ready", 32'(req_ready_o), 32'h1);
        chk("rd_mem_valid_grant_cycle", 32'(mem_req_valid_o), 32'h0);
        tick();
        req_valid_i = 2'b00;
        settle();
        chk("rd_mem_valid", 32'(mem_req_valid_o), 32'h1);
        chk("rd_addr", mem_req_addr_o, 32'h100);
        chk("rd_we", 32'(mem_req_we_o), 32'h0);
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        tick();
        tick();
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i = 32'hDEADBEEF;
        tick();
        mem_resp_valid_i = 1'b0;
        settle();
        chk("rd_resp_valid", 32'(resp_valid_o), 32'h1);
        chk("rd_resp_data", resp_data_o, 32'hDEADBEEF);
        chk("rd_busy_after", 32'(busy_o), 32'h0);
        tick();
        chk("rd_resp_pulse_end", 32'(resp_valid_o), 32'h0);

        // Round-robin with both requesters held valid
        do_reset();
        req_addr_i = {32'h2000, 32'h1000};
        req_valid_i = 2'b11;
        settle();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr%0d_ready", i), 32'(req_ready_o), (i % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            chk($sformatf("rr%0d_addr", i), mem_req_addr_o, (i % 2 == 0) ? 32'h1000 : 32'h2000);
            mem_req_ready_i = 1'b1;
            tick();
            mem_req_ready_i = 1'b0;
            mem_resp_valid_i = 1'b1;
            mem_resp_data_i = 32'hA0 + 32'(i);
            tick();
            mem_resp_valid_i = 1'b0;
            if (i == 3) req_valid_i = 2'b00;
            settle();
            chk($sformatf("rr%0d_resp_valid", i), 32'(resp_valid_o), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk($sformatf("rr%0d_resp_data", i), resp_data_o, 32'hA0 + 32'(i));
        end
        tick();
        tick();

        // Backpressure: memory holds off for 5 cycles
        xfer_cnt = 0;
        req_valid_i = 2'b10;
        req_we_i = 2'b10;
        req_addr_i[63:32] = 32'h300;
        req_wdata_i[63:32] = 32'h55AA55AA;
        settle();
        chk("bp_ready", 32'(req_ready_o), 32'h2);
        tick();
        req_valid_i = 2'b00;
        req_addr_i[63:32] = 32'hFFFF;
        req_wdata_i[63:32] = 32'h0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("bp%0d_valid", i), 32'(mem_req_valid_o), 32'h1);
            chk($sformatf("bp%0d_addr", i), mem_req_addr_o, 32'h300);
            chk($sformatf("bp%0d_we", i), 32'(mem_req_we_o), 32'h1);
            chk($sformatf("bp%0d_wdata", i), mem_req_wdata_o, 32'h55AA55AA);
            tick();
        end
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        settle();
        chk("bp_valid_dropped", 32'(mem_req_valid_o), 32'h0);
        chk("bp_busy_wait", 32'(busy_o), 32'h1);
        tick();
        mem_resp_valid_i = 1'b1;
        tick();
        mem_resp_valid_i = 1'b0;
        settle();
        chk("bp_resp_valid", 32'(resp_valid_o), 32'h2);
        chk("bp_xfer_count", 32'(xfer_cnt), 32'h1);

        // Flush squashes an ifetch response
        do_reset();
        req_valid_i = 2'b01;
        req_we_i = 2'b00;
        tick();
        req_valid_i = 2'b00;
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i = 32'h11111111;
        tick();
        mem_resp_valid_i = 1'b0;
        settle();
        chk("sq_resp_valid", 32'(resp_valid_o), 32'h0);
        chk("sq_busy", 32'(busy_o), 32'h0);
        // Same flush with dcache owner still delivers
        req_valid_i = 2'b10;
        settle();
        chk("sq_next_ready", 32'(req_ready_o), 32'h2);
        tick();
        req_valid_i = 2'b00;
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        mem_resp_valid_i = 1'b1;
        tick();
        mem_resp_valid_i = 1'b0;
        settle();
        chk("sq_owner1_resp", 32'(resp_valid_o), 32'h2);
        // Flush in the same cycle as the ifetch response
        req_valid_i = 2'b01;
        tick();
        req_valid_i = 2'b00;
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        flush_i = 1'b1;
        mem_resp_valid_i = 1'b1;
        tick();
        flush_i = 1'b0;
        mem_resp_valid_i = 1'b0;
        settle();
        chk("sq_same_cycle_resp", 32'(resp_valid_o), 32'h0);
        // Stray response in IDLE is ignored
        mem_resp_valid_i = 1'b1;
        tick();
        mem_resp_valid_i = 1'b0;
        settle();
        chk("stray_resp_valid", 32'(resp_valid_o), 32'h0);
        chk("stray_busy", 32'(busy_o), 32'h0);

        // Write by dcache
        req_valid_i = 2'b10;
        req_we_i = 2'b10;
        req_addr_i[63:32] = 32'h200;
        req_wdata_i[63:32] = 32'h12345678;
        tick();
        req_valid_i = 2'b00;
        settle();
        chk("wr_we", 32'(mem_req_we_o), 32'h1);
        chk("wr_addr", mem_req_addr_o, 32'h200);
        chk("wr_wdata", mem_req_wdata_o, 32'h12345678);
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        mem_resp_valid_i = 1'b1;
        tick();
        mem_resp_valid_i = 1'b0;
        settle();
        chk("wr_ack_resp", 32'(resp_valid_o), 32'h2);

        // Watchdog: no response
        req_valid_i = 2'b01;
        req_we_i = 2'b00;
        tick();
        req_valid_i = 2'b00;
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            settle();
            if (k == 15) chk("wd_err_cycle15", 32'(timeout_err_o), 32'h0);
            if (k == 16) begin
                chk("wd_err_cycle16", 32'(timeout_err_o), 32'h1);
                chk("wd_busy", 32'(busy_o), 32'h1);
            end
            if (k < 16) tick();
        end
        tick();
        settle();
        chk("wd_err_sticky", 32'(timeout_err_o), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("wd_err_cleared", 32'(timeout_err_o), 32'h0);
        chk("wd_busy_cleared", 32'(busy_o), 32'h0);

        // Reset while in ISSUE
        req_valid_i = 2'b01;
        req_addr_i[31:0] = 32'h440;
        req_wdata_i[31:0] = 32'h99;
        req_we_i = 2'b01;
        tick();
        req_valid_i = 2'b00;
        settle();
        chk("ri_issue", 32'(mem_req_valid_o), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_resp_valid_i = 1'b1;
        settle();
        chk("ri_mem_valid", 32'(mem_req_valid_o), 32'h0);
        chk("ri_req_ready", 32'(req_ready_o), 32'h0);
        chk("ri_resp_valid", 32'(resp_valid_o), 32'h0);
        chk("ri_busy", 32'(busy_o), 32'h0);
        chk("ri_addr", mem_req_addr_o, 32'h0);
        chk("ri_we", 32'(mem_req_we_o), 32'h0);
        chk("ri_wdata", mem_req_wdata_o, 32'h0);
        tick();
        mem_resp_valid_i = 1'b0;
        settle();
        chk("ri_no_resp", 32'(resp_valid_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single simulated-memory port between the instruction-fetch refill path (requester 0) and the data-cache refill/writeback path (requester 1). It sits between the processor's miss handlers and the AXI sim-memory interface. It allows one outstanding transaction at a time, grants round-robin, drops squashed fetch responses on pipeline flush, and flags hung memory with a watchdog.

## Interface
Parameters:
- ADDR_W, 32, request address width
- DATA_W, 32, data width per transaction
- TIMEOUT, 1024, maximum WAIT_RESP cycles before the error flag sets

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid_i  in  2  per-requester request valid
- req_we_i  in  2  per-requester write enable
- req_addr_i  in  2×ADDR_W  per-requester address
- req_wdata_i  in  2×DATA_W  per-requester write data
- req_ready_o  out  2  one-cycle pulse when that requester's request is latched
- resp_valid_o  out  2  one-cycle response pulse to the owning requester
- resp_data_o  out  DATA_W  response data, shared by both requesters
- flush_i  in  1  pipeline flush; squashes an in-flight requester-0 transaction
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory accepts the request
- mem_req_we_o  out  1  memory write enable
- mem_req_addr_o  out  ADDR_W  memory address
- mem_req_wdata_o  out  DATA_W  memory write data
- mem_resp_valid_i  in  1  memory response (reads and write-acks)
- mem_resp_data_i  in  DATA_W  memory read data
- busy_o  out  1  FSM is not IDLE
- timeout_err_o  out  1  sticky watchdog error

## Operation
- FSM states: IDLE, ISSUE, WAIT_RESP.
- **IDLE**
  - Arbitration: if exactly one req_valid_i bit is set, grant that requester. If both are set, grant the requester that is not last_grant.
  - On a grant: latch owner, we, addr and wdata; pulse req_ready_o[owner]; update last_grant; go to ISSUE.
- **ISSUE**
  - Drive mem_req_valid_o=1 with the latched fields.
  - When mem_req_ready_i=1, go to WAIT_RESP and clear the watchdog counter.
- **WAIT_RESP**
  - The watchdog counter increments each cycle.
  - On mem_resp_valid_i: register the data into resp_data_o, pulse resp_valid_o[owner] next cycle (unless squashed), and go to IDLE.
- **Squash**
  - A squash bit sets when flush_i=1 while owner=0 in ISSUE or WAIT_RESP.
  - The transaction still completes on the memory side, because the request cannot be withdrawn.
  - The response is consumed, resp_valid_o is suppressed, and the squash bit clears on return to IDLE.
  - flush_i has no effect when owner=1 or in IDLE.
- **Stray responses:** mem_resp_valid_i outside WAIT_RESP is ignored.
- **Watchdog:** when the counter reaches TIMEOUT-1, timeout_err_o sets and stays set until rst. The FSM keeps waiting.
- **Reset values:** all outputs 0; state=IDLE; last_grant=1, so requester 0 wins the first tie; counter and squash cleared.
- **Reset mid-transaction:** the transaction is abandoned with no response pulse. The memory side is expected to be reset together with this block.

## Timing
- **Grant:** req_valid_i sampled in IDLE at edge N. req_ready_o is combinational in cycle N. mem_req_valid_o goes high from cycle N+1.
- **Request hold:** mem_req_valid_o and its fields stay stable until the cycle mem_req_ready_i=1.
- **Response:** mem_resp_valid_i in cycle M produces resp_valid_o in cycle M+1. The FSM is IDLE at M+1 and can grant again in M+1.
- **Throughput:** best case is one transaction per 3 cycles (IDLE, ISSUE, WAIT with an immediate response).
- **Requester rules:** requesters hold req_valid_i and their fields until req_ready_o. Fields are captured only on the grant cycle.
- **Simultaneous flush_i and mem_resp_valid_i** with owner=0 in WAIT_RESP: the response is squashed.
- **Watchdog counter:** $clog2(TIMEOUT)+1 bits, saturating.

## Structure
- Shared package: arb_state_e enum (IDLE/ISSUE/WAIT_RESP) and requester IDs REQ_IFETCH=0, REQ_DCACHE=1.
- Sub-module: rr_arbiter2, a 2-way round-robin grant with a last_grant register.
- Everything else is a single module.

## Test plan
- **Single read:** req 0 read at addr 0x100 with memory returning 0xDEADBEEF after 3 cycles -> req_ready_o[0] in cycle N, mem_req_valid_o in N+1, resp_valid_o[0]=1 and resp_data_o=0xDEADBEEF one cycle after mem_resp_valid_i.
- **Round-robin:** both requesters held valid for 4 transactions -> grant order 0,1,0,1. resp_valid_o goes only to the owner.
- **Backpressure:** mem_req_ready_i held low for 5 cycles -> mem_req_addr_o/mem_req_we_o/mem_req_wdata_o stable throughout, and exactly one transfer occurs.
- **Flush squash:** req 0 in WAIT_RESP, flush_i pulsed, then response arrives -> no resp_valid_o[0], FSM returns to IDLE, next grant proceeds. The same flush with owner=1 still delivers resp_valid_o[1].
- **Watchdog:** TIMEOUT=16 with no memory response -> timeout_err_o=1 on the 16th WAIT_RESP cycle, busy_o stays 1, and rst clears both.
- **Write and reset:** req 1 write 0x12345678 to 0x200 -> mem_req_we_o=1 and a write-ack produces resp_valid_o[1]. A separate run asserts rst in ISSUE -> all outputs 0 the next cycle and no response pulse.
